// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port ids,
// memory depth and the address-legality screen.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } dmem_state_t;

  localparam logic PORT_LSU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int DMEM_WORDS = 256;

  // Misaligned or past the last word: the access never reaches memory.
  function automatic logic dmem_addr_bad(input logic [31:0] addr, input int words);
    return (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(words));
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way grant picker: round-robin, or fixed priority to port 0 with a
// starvation guard that forces a port-1 win after MAX_WAIT straight losses.
module dmem_rr_pick
  import dmem_pkg::*;
#(
  parameter int PRIO_MODE = 0,
  parameter int MAX_WAIT  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic req0,
  input  logic req1,
  output logic fire,
  output logic grant
);

  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic          last_grant;
  logic [WW-1:0] wait_cnt;
  logic          wait_full;

  assign wait_full = (wait_cnt == WW'(MAX_WAIT));

  always_comb begin
    fire  = arb_en & (req0 | req1);
    grant = req1 & ~req0;
    if (req0 && req1) begin
      if (PRIO_MODE == 0) grant = ~last_grant;
      else                grant = wait_full;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= PORT_DMA;
      wait_cnt   <= '0;
    end else if (fire) begin
      last_grant <= grant;
      // wait_cnt only tracks contention seen by port 1
      if (PRIO_MODE != 0 && req1) begin
        if (grant)           wait_cnt <= '0;
        else if (!wait_full) wait_cnt <= wait_cnt + WW'(1);
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the core LSU (port 0) and the
// loader/debug DMA (port 1); one transaction in flight, ARB -> ACCESS -> RESP.
module data_mem_arbiter
  import dmem_pkg::*;
#(
  parameter int PRIO_MODE = 0,
  parameter int MAX_WAIT  = 4,
  parameter int MEM_WORDS = DMEM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  dmem_state_t state;
  logic        txn_port;
  logic        txn_we;
  logic        txn_err;
  logic [31:0] txn_addr;
  logic [31:0] txn_wdata;

  logic        fire;
  logic        grant;
  logic        win_we;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic [31:0] rd_word;

  dmem_rr_pick #(
    .PRIO_MODE (PRIO_MODE),
    .MAX_WAIT  (MAX_WAIT)
  ) u_pick (
    .clk    (clk),
    .reset  (reset),
    .arb_en (state == ST_ARB),
    .req0   (p0_req),
    .req1   (p1_req),
    .fire   (fire),
    .grant  (grant)
  );

  always_comb begin
    win_we    = grant ? p1_we    : p0_we;
    win_addr  = grant ? p1_addr  : p0_addr;
    win_wdata = grant ? p1_wdata : p0_wdata;
  end

  // Memory side sees only registered state and txn regs, never the requests.
  assign mem_read  = (state == ST_ACCESS) && !txn_err && !txn_we;
  assign mem_write = (state == ST_ACCESS) && !txn_err &&  txn_we;
  assign mem_addr  = txn_addr;
  assign mem_wdata = txn_wdata;
  assign rd_word   = (txn_err || txn_we) ? 32'h0 : mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_ARB;
      txn_port  <= PORT_LSU;
      txn_we    <= 1'b0;
      txn_err   <= 1'b0;
      txn_addr  <= '0;
      txn_wdata <= '0;
      p0_ack    <= 1'b0;
      p0_err    <= 1'b0;
      p0_rdata  <= '0;
      p1_ack    <= 1'b0;
      p1_err    <= 1'b0;
      p1_rdata  <= '0;
    end else begin
      p0_ack   <= 1'b0;
      p0_err   <= 1'b0;
      p0_rdata <= '0;
      p1_ack   <= 1'b0;
      p1_err   <= 1'b0;
      p1_rdata <= '0;
      case (state)
        ST_ARB: begin
          if (fire) begin
            txn_port  <= grant;
            txn_we    <= win_we;
            txn_addr  <= win_addr;
            txn_wdata <= win_wdata;
            txn_err   <= dmem_addr_bad(win_addr, MEM_WORDS);
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Load data is captured straight into the winner's response reg.
          if (txn_port == PORT_DMA) begin
            p1_ack   <= 1'b1;
            p1_err   <= txn_err;
            p1_rdata <= rd_word;
          end else begin
            p0_ack   <= 1'b1;
            p0_err   <= txn_err;
            p0_rdata <= rd_word;
          end
          state <= ST_RESP;
        end
        ST_RESP: state <= ST_ARB;
        default: state <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: round-robin and fixed-priority instances, each
// with its own memory, checked cycle by cycle against a transaction-level model.
module tb_data_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  logic clk = 1'b0;
  logic reset;
  logic mem_clr;

  logic        req0 [2], we0 [2], req1 [2], we1 [2];
  logic [31:0] addr0 [2], wdata0 [2], addr1 [2], wdata1 [2];
  logic        ack0 [2], err0 [2], ack1 [2], err1 [2];
  logic [31:0] rdata0 [2], rdata1 [2];
  logic        mrd [2], mwr [2];
  logic [31:0] maddr [2], mwd [2], mrdata [2];
  logic [31:0] mem [2][256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    data_mem_arbiter #(.PRIO_MODE(g), .MAX_WAIT(4), .MEM_WORDS(256)) u_dut (
      .clk(clk), .reset(reset),
      .p0_req(req0[g]), .p0_we(we0[g]), .p0_addr(addr0[g]), .p0_wdata(wdata0[g]),
      .p0_ack(ack0[g]), .p0_err(err0[g]), .p0_rdata(rdata0[g]),
      .p1_req(req1[g]), .p1_we(we1[g]), .p1_addr(addr1[g]), .p1_wdata(wdata1[g]),
      .p1_ack(ack1[g]), .p1_err(err1[g]), .p1_rdata(rdata1[g]),
      .mem_read(mrd[g]), .mem_write(mwr[g]), .mem_addr(maddr[g]),
      .mem_wdata(mwd[g]), .mem_rdata(mrdata[g]));

    always @(posedge clk) begin
      if (mem_clr) begin
        for (int i = 0; i < 256; i++) mem[g][i] <= '0;
      end else if (mwr[g]) begin
        mem[g][maddr[g][9:2]] <= mwd[g];
      end
    end
    assign mrdata[g] = mem[g][maddr[g][9:2]];
  end

  // Reference model state
  op_t         q0 [$];
  op_t         q1 [$];
  logic [31:0] ref_mem [2][256];
  int          d;
  int          phase;
  op_t         cur;
  int          cur_port;
  int          last_g [2];
  int          losses [2];
  int          cyc;
  int          ack_order [$];
  int          ack_cyc [$];
  logic [31:0] last_rd;
  logic        last_err;
  int          vectors;
  int          errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd1024);
  endfunction

  function automatic int qsize(input int p);
    return (p != 0) ? q1.size() : q0.size();
  endfunction

  function automatic op_t q_front(input int p);
    return (p != 0) ? q1[0] : q0[0];
  endfunction

  task automatic q_pop(input int p);
    if (p != 0) void'(q1.pop_front());
    else        void'(q0.pop_front());
  endtask

  // Arbitration rules at transaction level: alternate, or port 0 first
  // unless port 1 has already lost four times in a row.
  function automatic int pick();
    int w;
    if (qsize(0) > 0 && qsize(1) > 0) begin
      if (d == 0) w = (last_g[d] == 1) ? 0 : 1;
      else        w = (losses[d] >= 4) ? 1 : 0;
    end else begin
      w = (qsize(0) > 0) ? 0 : 1;
    end
    last_g[d] = w;
    if (d == 1 && qsize(1) > 0) losses[d] = (w == 1) ? 0 : ((losses[d] < 4) ? losses[d] + 1 : 4);
    return w;
  endfunction

  task automatic drive();
    op_t f0, f1;
    f0 = (q0.size() > 0) ? q0[0] : '0;
    f1 = (q1.size() > 0) ? q1[0] : '0;
    for (int g = 0; g < 2; g++) begin
      req0[g]   = (g == d) && (q0.size() > 0);
      we0[g]    = (g == d) ? f0.we : 1'b0;
      addr0[g]  = (g == d) ? f0.addr : '0;
      wdata0[g] = (g == d) ? f0.wdata : '0;
      req1[g]   = (g == d) && (q1.size() > 0);
      we1[g]    = (g == d) ? f1.we : 1'b0;
      addr1[g]  = (g == d) ? f1.addr : '0;
      wdata1[g] = (g == d) ? f1.wdata : '0;
    end
  endtask

  task automatic tick(input bit rst);
    int          nphase;
    int          w;
    logic        bad;
    logic [31:0] exp_rd;
    logic        obs_err;
    logic [31:0] obs_rd;
    reset  = rst;
    nphase = phase;
    if (rst) begin
      // A store already on the bus commits at the reset edge; the txn is dropped.
      if (phase == 1) begin
        if (cur.we && !addr_bad(cur.addr)) ref_mem[d][cur.addr[9:2]] = cur.wdata;
        q_pop(cur_port);
      end
      nphase = 0;
      last_g = '{1, 1};
      losses = '{0, 0};
    end else if (phase == 0) begin
      if (qsize(0) > 0 || qsize(1) > 0) begin
        w        = pick();
        cur      = q_front(w);
        cur_port = w;
        nphase   = 1;
      end
    end else begin
      nphase = (phase == 1) ? 2 : 0;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    phase = nphase;
    bad   = addr_bad(cur.addr);
    chk("p0_ack", 32'(ack0[d]), 32'(phase == 2 && cur_port == 0));
    chk("p1_ack", 32'(ack1[d]), 32'(phase == 2 && cur_port == 1));
    chk("mem_read", 32'(mrd[d]), 32'(phase == 1 && !bad && !cur.we));
    chk("mem_write", 32'(mwr[d]), 32'(phase == 1 && !bad && cur.we));
    if (phase == 1 && !bad) begin
      chk("mem_addr", maddr[d], cur.addr);
      if (cur.we) chk("mem_wdata", mwd[d], cur.wdata);
    end
    if (phase == 2) begin
      exp_rd = (bad || cur.we) ? 32'h0 : ref_mem[d][cur.addr[9:2]];
      if (!bad && cur.we) ref_mem[d][cur.addr[9:2]] = cur.wdata;
      obs_err = (cur_port != 0) ? err1[d] : err0[d];
      obs_rd  = (cur_port != 0) ? rdata1[d] : rdata0[d];
      chk("err", 32'(obs_err), 32'(bad));
      chk("rdata", obs_rd, exp_rd);
      last_rd  = obs_rd;
      last_err = obs_err;
      ack_order.push_back(cur_port);
      ack_cyc.push_back(cyc);
      q_pop(cur_port);
    end
    drive();
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((phase != 0 || q0.size() > 0 || q1.size() > 0) && n < budget) begin
      tick(1'b0);
      n++;
    end
    chk("drain_timeout", 32'(n >= budget), 32'h0);
  endtask

  function automatic op_t rand_op();
    op_t o;
    int  k;
    k       = $urandom_range(0, 7);
    o.we    = 1'($urandom_range(0, 1));
    o.wdata = $urandom();
    if (k == 0)      o.addr = 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
    else if (k == 1) o.addr = 32'd1024 + 32'($urandom_range(0, 255) * 4);
    else             o.addr = 32'($urandom_range(0, 255) * 4);
    return o;
  endfunction

  task automatic random_phase(input int dut, input int cycles);
    op_t o;
    d = dut;
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        o = rand_op();
        if ($urandom_range(0, 1) == 0) begin
          if (q0.size() < 3) q0.push_back(o);
        end else begin
          if (q1.size() < 3) q1.push_back(o);
        end
      end
      drive();
      tick(1'b0);
    end
    run_idle(200);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int exp2 [8];
    int exp3 [10];
    vectors  = 0;
    errors   = 0;
    cyc      = 0;
    phase    = 0;
    cur      = '0;
    cur_port = 0;
    d        = 0;
    last_g   = '{1, 1};
    losses   = '{0, 0};
    last_rd  = '0;
    last_err = 1'b0;
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 256; i++) ref_mem[g][i] = '0;
    mem_clr = 1'b1;
    drive();
    tick(1'b1);
    tick(1'b1);
    mem_clr = 1'b0;

    // Reset state of both instances
    for (int g = 0; g < 2; g++) begin
      chk("rst_p0_err", 32'(err0[g]), 32'h0);
      chk("rst_p1_err", 32'(err1[g]), 32'h0);
      chk("rst_p0_rdata", rdata0[g], 32'h0);
      chk("rst_p1_rdata", rdata1[g], 32'h0);
      chk("rst_mem_addr", maddr[g], 32'h0);
      chk("rst_mem_wdata", mwd[g], 32'h0);
    end

    // 1: port 0 store then load at 0x40, ack two cycles after ARB
    d = 0;
    ack_cyc.delete();
    q0.push_back('{1'b1, 32'h40, 32'hDEADBEEF});
    q0.push_back('{1'b0, 32'h40, 32'h0});
    drive();
    c0 = cyc;
    run_idle(50);
    chk("t1_load_data", last_rd, 32'hDEADBEEF);
    chk("t1_load_err", 32'(last_err), 32'h0);
    chk("t1_store_lat", 32'(ack_cyc[0] - c0), 32'd2);
    chk("t1_load_lat", 32'(ack_cyc[1] - c0), 32'd5);

    // 2: round-robin, both requesting after reset
    tick(1'b1);
    d = 0;
    ack_order.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{1'b1, 32'(i * 4 + 32'h100), 32'($urandom())});
      q1.push_back('{1'b1, 32'(i * 4 + 32'h200), 32'($urandom())});
    end
    drive();
    run_idle(100);
    exp2 = '{0, 1, 0, 1, 0, 1, 0, 1};
    for (int i = 0; i < 8; i++) chk($sformatf("t2_grant%0d", i), 32'(ack_order[i]), 32'(exp2[i]));

    // 3: fixed priority with starvation guard
    tick(1'b1);
    d = 1;
    ack_order.delete();
    for (int i = 0; i < 8; i++) q0.push_back('{1'b0, 32'(i * 4), 32'h0});
    for (int i = 0; i < 2; i++) q1.push_back('{1'b1, 32'(i * 4 + 32'h300), 32'($urandom())});
    drive();
    run_idle(100);
    exp3 = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < 10; i++) chk($sformatf("t3_grant%0d", i), 32'(ack_order[i]), 32'(exp3[i]));

    // 4: illegal addresses from port 1
    d = 0;
    q1.push_back('{1'b0, 32'h402, 32'h0});
    drive();
    run_idle(20);
    chk("t4_misalign_err", 32'(last_err), 32'h1);
    q1.push_back('{1'b0, 32'h400, 32'h0});
    q1.push_back('{1'b1, 32'h401, 32'hFFFF_FFFF});
    drive();
    run_idle(20);
    chk("t4_range_err", 32'(last_err), 32'h1);
    chk("t4_rdata", last_rd, 32'h0);

    // 5: reset while a port-1 store is in ACCESS
    d = 0;
    q1.push_back('{1'b1, 32'h3FC, 32'h12345678});
    drive();
    tick(1'b0);
    tick(1'b1);
    q1.push_back('{1'b0, 32'h3FC, 32'h0});
    drive();
    c0 = cyc;
    ack_cyc.delete();
    run_idle(20);
    chk("t5_load_data", last_rd, 32'h12345678);
    chk("t5_arb_after_rst", 32'(ack_cyc[0] - c0), 32'd2);

    // 6: back-to-back transactions from a single requester
    d = 0;
    ack_cyc.delete();
    for (int i = 0; i < 4; i++) q0.push_back('{1'(i % 2), 32'h80, 32'(32'hA000 + i)});
    drive();
    run_idle(40);
    for (int i = 0; i < 3; i++) chk($sformatf("t6_spacing%0d", i), 32'(ack_cyc[i + 1] - ack_cyc[i]), 32'd3);

    // Randomized traffic on both arbitration modes
    random_phase(0, 400);
    random_phase(1, 400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
